// File: rtl/bp_pkg.sv
// Shared types and sizing for the direct-mapped branch predictor.
// Counter encodings, default table size and the tag-width helper.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam int DEF_IDX_BITS = 4;

    function automatic int tag_bits(input int pc_bits, input int idx_bits);
        return pc_bits - idx_bits;
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Two-bit saturating counter next-state function.
import bp_pkg::*;

module bp_sat_cnt (
    input  cnt_e cnt_i,
    input  logic taken_i,
    output cnt_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != ST) cnt_o = cnt_e'(cnt_i + 2'd1);
        end else begin
            if (cnt_i != SNT) cnt_o = cnt_e'(cnt_i - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational from registered state; updates land on the clock edge.
import bp_pkg::*;

module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int PC_BITS  = 12,
    parameter int IDX_BITS = DEF_IDX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_BITS-1:0]  F_pc,
    output logic                F_BP_taken,
    output logic [PC_BITS-1:0]  F_BP_target_pc,
    input  logic                EX_brn,
    input  logic [PC_BITS-1:0]  EX_pc,
    input  logic                EX_true_taken,
    input  logic [XLEN-1:0]     EX_alu_out,
    input  logic                EX_taken,
    output logic [31:0]         BP_n_branches,
    output logic [31:0]         BP_n_mispredicts
);

    localparam int TAG_W   = tag_bits(PC_BITS, IDX_BITS);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic               valid_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [PC_BITS-1:0] tgt_q   [ENTRIES];
    cnt_e               cnt_q   [ENTRIES];

    logic               valid_d [ENTRIES];
    logic [TAG_W-1:0]   tag_d   [ENTRIES];
    logic [PC_BITS-1:0] tgt_d   [ENTRIES];
    cnt_e               cnt_d   [ENTRIES];

    logic [31:0] n_br_q, n_br_d;
    logic [31:0] n_mis_q, n_mis_d;

    logic [IDX_BITS-1:0] f_idx, ex_idx;
    logic [TAG_W-1:0]    f_tag, ex_tag;
    logic                f_hit, ex_hit;
    cnt_e                cnt_upd;

    // Only the low PC_BITS of the resolved target are stored.
    logic unused_alu;
    assign unused_alu = ^EX_alu_out;

    assign f_idx  = F_pc[IDX_BITS-1:0];
    assign f_tag  = F_pc[PC_BITS-1:IDX_BITS];
    assign ex_idx = EX_pc[IDX_BITS-1:0];
    assign ex_tag = EX_pc[PC_BITS-1:IDX_BITS];

    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign F_BP_taken     = f_hit && cnt_q[f_idx][1];
    assign F_BP_target_pc = F_BP_taken ? tgt_q[f_idx] : F_pc + PC_BITS'(1);

    bp_sat_cnt u_sat_cnt (
        .cnt_i   (cnt_q[ex_idx]),
        .taken_i (EX_true_taken),
        .cnt_o   (cnt_upd)
    );

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        n_br_d  = n_br_q;
        n_mis_d = n_mis_q;
        if (EX_brn) begin
            n_br_d = n_br_q + 32'd1;
            if (EX_taken) n_mis_d = n_mis_q + 32'd1;
            if (ex_hit) begin
                cnt_d[ex_idx] = cnt_upd;
                if (EX_true_taken) tgt_d[ex_idx] = EX_alu_out[PC_BITS-1:0];
            end else if (EX_true_taken) begin
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                tgt_d[ex_idx]   = EX_alu_out[PC_BITS-1:0];
                cnt_d[ex_idx]   = WT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= WNT;
            end
            n_br_q  <= '0;
            n_mis_q <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            n_br_q  <= n_br_d;
            n_mis_q <= n_mis_d;
        end
    end

    assign BP_n_branches    = n_br_q;
    assign BP_n_mispredicts = n_mis_q;

endmodule
